axi_read_arbiter: RTL and testbench
===================================

Name: axi_read_arbiter

Overview:
- Upstream control stage for the interconnect read-address mux.
- Arbitrates between masters M0 (IF) and M1 (MEM) for the read path and decodes the winner's ARADDR to a target: S0 (IM), S1 (DM) or the default slave SD (DECERR).
- Drives the mux's `Aibiter_Read_State_control` and `Arbiter_ARID_control` inputs.
- Holds each grant until the granted burst's last R beat completes.

Parameters:
- S0_BASE, 32'h0000_0000, S0 region base address.
- S1_BASE, 32'h0001_0000, S1 region base address.
- REGION_MASK, 32'hFFFF_0000, mask applied to ARADDR before base compare; a miss on both regions selects SD.

Ports:
- ACLK  in  1  clock
- ARESETn  in  1  asynchronous active-low reset
- ARVALID_M0 / ARVALID_M1  in  1  master read-address valid
- ARADDR_M0 / ARADDR_M1  in  32  master read address
- RREADY_M0 / RREADY_M1  in  1  master read-data ready
- ARREADY_S0 / ARREADY_S1 / ARREADY_SD  in  1  slave read-address ready
- RVALID_S0 / RVALID_S1 / RVALID_SD  in  1  slave read-data valid
- RLAST_S0 / RLAST_S1 / RLAST_SD  in  1  slave read last beat
- Aibiter_Read_State_control  out  2  00 IDLE, 01 ADDR, 10 DATA
- Arbiter_ARID_control  out  4  bit3 = granted master; bits[2:0] one-hot target (001 S0, 010 S1, 100 SD); 4'b0000 = no grant
- rd_busy  out  1  high in ADDR or DATA

Behaviour:
- Reset: ARESETn is asynchronous, active-low; clock is ACLK. During reset: state IDLE, grant register 4'b0000, round-robin pointer points to M0, all outputs 0.
- State encoding drives `Aibiter_Read_State_control` directly from the state register.
- IDLE:
  - Requester selection is combinational. Fixed-priority build: M0 wins over M1.
  - `Arbiter_ARID_control` = {winner, decode(ARADDR_winner)}, or 0 if no ARVALID.
  - Target ready = ARREADY of the decoded target.
  - ARVALID & target ready: latch control into the grant register, go to DATA.
  - ARVALID & !ready: latch control, go to ADDR.
- ADDR:
  - Outputs come from the grant register.
  - Competing ARVALID is ignored.
  - Target ARREADY = 1 -> DATA.
- DATA:
  - Outputs come from the grant register.
  - Beat = RVALID_target & RREADY_granted-master.
  - Beat & RLAST_target -> IDLE; the grant register clears to 0 on that edge.
  - Non-last beats hold DATA.
  - RLAST without RVALID & RREADY is ignored.
- Address latency: zero (combinational control in IDLE). Release latency: 1 cycle after the last beat; new arbitration happens the cycle after RLAST.
- Simultaneous events:
  - Both ARVALIDs in IDLE are resolved by the priority rule.
  - R signals seen during IDLE/ADDR are ignored.
  - A master dropping ARVALID while in ADDR is an AXI violation. No recovery: the arbiter stays in ADDR.
- Decode: (addr & REGION_MASK) == S0_BASE -> S0; == S1_BASE -> S1; else SD.
- Reset mid-burst: immediate return to IDLE, control outputs 0, pointer back to M0.

Optional Feature:
- Macro: AXI_RD_RR_EN.
- Defined: round-robin arbitration. A 1-bit pointer is set to the master NOT granted, updated on each AR handshake. When both masters request in IDLE, the pointer's master wins.
- Undefined: fixed priority, M0 always wins; pointer logic is absent.

Test Plan:
- M0 ARADDR=0x0000_0040, ARREADY_S0=1 same cycle -> control 4'b0001 state 00, then state 10. Three-beat burst with RLAST on beat 3 -> state 00 and control 0 the following cycle.
- M1 ARADDR=0x0001_0008, ARREADY_S1 low 3 cycles -> control 4'b1010. State sequence 00, 01 x3, then 10 when ARREADY_S1 rises.
- M0 ARADDR=0x0003_0000 -> control 4'b0100, target SD; RLAST_SD beat -> return to IDLE.
- Both ARVALID every cycle, all bursts single-beat:
  - Without AXI_RD_RR_EN: grants M0 every time.
  - With AXI_RD_RR_EN: grants alternate M0, M1, M0, M1.
- DATA phase, RVALID_S1=1 & RLAST_S1=1 but RREADY_M0=0 for 2 cycles -> state stays 10, exits only after RREADY_M0=1.
- ARESETn pulsed low mid-DATA -> state 00, control 4'b0000, rd_busy 0 asynchronously. First grant after reset goes to M0.

Source files
------------

// File: rtl/axi_read_arbiter_if.sv
// axi_read_arbiter_if: master-side AR/R handshakes, slave readies and arbiter control outputs
interface axi_read_arbiter_if;
    logic        ARVALID_M0;
    logic        ARVALID_M1;
    logic [31:0] ARADDR_M0;
    logic [31:0] ARADDR_M1;
    logic        RREADY_M0;
    logic        RREADY_M1;
    logic        ARREADY_S0;
    logic        ARREADY_S1;
    logic        ARREADY_SD;
    logic        RVALID_S0;
    logic        RVALID_S1;
    logic        RVALID_SD;
    logic        RLAST_S0;
    logic        RLAST_S1;
    logic        RLAST_SD;
    logic [1:0]  Aibiter_Read_State_control;
    logic [3:0]  Arbiter_ARID_control;
    logic        rd_busy;

    modport master (
        output ARVALID_M0, ARVALID_M1, ARADDR_M0, ARADDR_M1, RREADY_M0, RREADY_M1,
               ARREADY_S0, ARREADY_S1, ARREADY_SD, RVALID_S0, RVALID_S1, RVALID_SD,
               RLAST_S0, RLAST_S1, RLAST_SD,
        input  Aibiter_Read_State_control, Arbiter_ARID_control, rd_busy
    );

    modport slave (
        input  ARVALID_M0, ARVALID_M1, ARADDR_M0, ARADDR_M1, RREADY_M0, RREADY_M1,
               ARREADY_S0, ARREADY_S1, ARREADY_SD, RVALID_S0, RVALID_S1, RVALID_SD,
               RLAST_S0, RLAST_S1, RLAST_SD,
        output Aibiter_Read_State_control, Arbiter_ARID_control, rd_busy
    );
endinterface

// File: rtl/axi_read_arbiter.sv
// axi_read_arbiter: arbitrates M0/M1 read requests, decodes to S0/S1/SD, holds grant until last R beat.
// Define AXI_RD_RR_EN for round-robin arbitration; otherwise M0 has fixed priority.
module axi_read_arbiter #(
    parameter logic [31:0] S0_BASE     = 32'h0000_0000,
    parameter logic [31:0] S1_BASE     = 32'h0001_0000,
    parameter logic [31:0] REGION_MASK = 32'hFFFF_0000
) (
    input logic               ACLK,
    input logic               ARESETn,
    axi_read_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'b00, ADDR = 2'b01, DATA = 2'b10} state_t;

    state_t      state_q, state_d;
    logic [3:0]  grant_q, grant_d;
    logic        winner;
    logic        any_req;
    logic [31:0] win_addr;
    logic [3:0]  req_ctrl;
    logic [2:0]  tgt;
    logic        tgt_rdy;
    logic        rvalid_t;
    logic        rlast_t;
    logic        rready_g;
    logic        r_done;

    function automatic logic [2:0] decode(input logic [31:0] a);
        return ((a & REGION_MASK) == S0_BASE) ? 3'b001 :
               ((a & REGION_MASK) == S1_BASE) ? 3'b010 : 3'b100;
    endfunction

    assign any_req = bus.ARVALID_M0 | bus.ARVALID_M1;

`ifdef AXI_RD_RR_EN
    logic ptr_q, ptr_d;
    logic ar_hs;
    logic hs_mst;
    assign winner = (bus.ARVALID_M0 & bus.ARVALID_M1) ? ptr_q : ~bus.ARVALID_M0;
`else
    assign winner = ~bus.ARVALID_M0;
`endif

    assign win_addr = winner ? bus.ARADDR_M1 : bus.ARADDR_M0;
    assign req_ctrl = any_req ? {winner, decode(win_addr)} : 4'b0000;

    assign tgt      = (state_q == IDLE) ? req_ctrl[2:0] : grant_q[2:0];
    assign tgt_rdy  = |(tgt & {bus.ARREADY_SD, bus.ARREADY_S1, bus.ARREADY_S0});
    assign rvalid_t = |(grant_q[2:0] & {bus.RVALID_SD, bus.RVALID_S1, bus.RVALID_S0});
    assign rlast_t  = |(grant_q[2:0] & {bus.RLAST_SD, bus.RLAST_S1, bus.RLAST_S0});
    assign rready_g = grant_q[3] ? bus.RREADY_M1 : bus.RREADY_M0;
    assign r_done   = rvalid_t & rready_g & rlast_t;

    // Next-state and grant-register update; R signals only matter in DATA
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        case (state_q)
            IDLE: begin
                grant_d = any_req ? req_ctrl : grant_q;
                state_d = !any_req ? IDLE : (tgt_rdy ? DATA : ADDR);
            end
            ADDR: state_d = tgt_rdy ? DATA : ADDR;
            DATA: begin
                state_d = r_done ? IDLE : DATA;
                grant_d = r_done ? 4'b0000 : grant_q;
            end
            default: begin
                state_d = IDLE;
                grant_d = 4'b0000;
            end
        endcase
    end

    // FSM state and grant register
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q <= IDLE;
            grant_q <= 4'b0000;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
        end
    end

`ifdef AXI_RD_RR_EN
    assign ar_hs  = tgt_rdy & ((state_q == IDLE & any_req) | (state_q == ADDR));
    assign hs_mst = (state_q == IDLE) ? req_ctrl[3] : grant_q[3];
    assign ptr_d  = ar_hs ? ~hs_mst : ptr_q;

    // Round-robin pointer moves to the master not granted on every AR handshake
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) ptr_q <= 1'b0;
        else          ptr_q <= ptr_d;
    end
`endif

    assign bus.Aibiter_Read_State_control = state_q;
    assign bus.Arbiter_ARID_control       = (state_q != IDLE) ? grant_q : (ARESETn ? req_ctrl : 4'b0000);
    assign bus.rd_busy                    = (state_q != IDLE);
endmodule

// File: tb/tb_axi_read_arbiter.sv
// tb_axi_read_arbiter: directed tests of arbitration, decode, burst hold and reset
module tb_axi_read_arbiter;
    logic ACLK;
    logic ARESETn;
    int   cmp;
    int   errs;

    axi_read_arbiter_if bus();

    axi_read_arbiter dut (
        .ACLK    (ACLK),
        .ARESETn (ARESETn),
        .bus     (bus)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    task automatic tick;
        @(posedge ACLK);
        #1;
    endtask

    task automatic clear_inputs;
        bus.ARVALID_M0 = 0; bus.ARVALID_M1 = 0;
        bus.ARADDR_M0  = '0; bus.ARADDR_M1 = '0;
        bus.RREADY_M0  = 0; bus.RREADY_M1 = 0;
        bus.ARREADY_S0 = 0; bus.ARREADY_S1 = 0; bus.ARREADY_SD = 0;
        bus.RVALID_S0  = 0; bus.RVALID_S1 = 0; bus.RVALID_SD = 0;
        bus.RLAST_S0   = 0; bus.RLAST_S1 = 0; bus.RLAST_SD = 0;
    endtask

    task automatic test_reset;
        clear_inputs();
        ARESETn = 0;
        bus.ARVALID_M0 = 1;
        repeat (2) tick();
        cmp++; if (bus.Aibiter_Read_State_control !== 2'b00) begin errs++; $display("FAIL reset_state got %b exp 00", bus.Aibiter_Read_State_control); end
        cmp++; if (bus.Arbiter_ARID_control !== 4'b0000) begin errs++; $display("FAIL reset_ctrl got %b exp 0000", bus.Arbiter_ARID_control); end
        cmp++; if (bus.rd_busy !== 1'b0) begin errs++; $display("FAIL reset_busy got %b exp 0", bus.rd_busy); end
        bus.ARVALID_M0 = 0;
        ARESETn = 1;
        tick();
        cmp++; if (bus.Aibiter_Read_State_control !== 2'b00) begin errs++; $display("FAIL post_reset_state got %b exp 00", bus.Aibiter_Read_State_control); end
    endtask

    task automatic test_back_to_back;
        logic [3:0] exp;
        bus.ARVALID_M0 = 1; bus.ARADDR_M0 = 32'h0000_0100;
        bus.ARVALID_M1 = 1; bus.ARADDR_M1 = 32'h0001_0100;
        bus.ARREADY_S0 = 1; bus.ARREADY_S1 = 1;
        bus.RVALID_S0 = 1; bus.RLAST_S0 = 1; bus.RVALID_S1 = 1; bus.RLAST_S1 = 1;
        bus.RREADY_M0 = 1; bus.RREADY_M1 = 1;
        for (int i = 0; i < 4; i++) begin
`ifdef AXI_RD_RR_EN
            exp = (i % 2 == 0) ? 4'b0001 : 4'b1010;
`else
            exp = 4'b0001;
`endif
            #1;
            cmp++; if (bus.Arbiter_ARID_control !== exp) begin errs++; $display("FAIL b2b_grant%0d got %b exp %b", i, bus.Arbiter_ARID_control, exp); end
            tick();
            cmp++; if (bus.Aibiter_Read_State_control !== 2'b10 || bus.Arbiter_ARID_control !== exp) begin errs++; $display("FAIL b2b_data%0d got st %b ctrl %b exp st 10 ctrl %b", i, bus.Aibiter_Read_State_control, bus.Arbiter_ARID_control, exp); end
            tick();
            cmp++; if (bus.Aibiter_Read_State_control !== 2'b00) begin errs++; $display("FAIL b2b_idle%0d got %b exp 00", i, bus.Aibiter_Read_State_control); end
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_s0_burst;
        bus.ARVALID_M0 = 1; bus.ARADDR_M0 = 32'h0000_0040; bus.ARREADY_S0 = 1;
        #1;
        cmp++; if (bus.Arbiter_ARID_control !== 4'b0001) begin errs++; $display("FAIL s0_ctrl got %b exp 0001", bus.Arbiter_ARID_control); end
        cmp++; if (bus.Aibiter_Read_State_control !== 2'b00) begin errs++; $display("FAIL s0_idle got %b exp 00", bus.Aibiter_Read_State_control); end
        tick();
        bus.ARVALID_M0 = 0; bus.ARREADY_S0 = 0;
        #1;
        cmp++; if (bus.Aibiter_Read_State_control !== 2'b10) begin errs++; $display("FAIL s0_data got %b exp 10", bus.Aibiter_Read_State_control); end
        cmp++; if (bus.Arbiter_ARID_control !== 4'b0001) begin errs++; $display("FAIL s0_hold got %b exp 0001", bus.Arbiter_ARID_control); end
        cmp++; if (bus.rd_busy !== 1'b1) begin errs++; $display("FAIL s0_busy got %b exp 1", bus.rd_busy); end
        bus.RVALID_S0 = 1; bus.RREADY_M0 = 1; bus.RLAST_S0 = 0;
        tick();
        cmp++; if (bus.Aibiter_Read_State_control !== 2'b10) begin errs++; $display("FAIL s0_beat1 got %b exp 10", bus.Aibiter_Read_State_control); end
        tick();
        cmp++; if (bus.Aibiter_Read_State_control !== 2'b10) begin errs++; $display("FAIL s0_beat2 got %b exp 10", bus.Aibiter_Read_State_control); end
        bus.RLAST_S0 = 1;
        tick();
        cmp++; if (bus.Aibiter_Read_State_control !== 2'b00) begin errs++; $display("FAIL s0_last_state got %b exp 00", bus.Aibiter_Read_State_control); end
        cmp++; if (bus.Arbiter_ARID_control !== 4'b0000) begin errs++; $display("FAIL s0_last_ctrl got %b exp 0000", bus.Arbiter_ARID_control); end
        clear_inputs();
    endtask

    task automatic test_s1_wait;
        bus.ARVALID_M1 = 1; bus.ARADDR_M1 = 32'h0001_0008;
        #1;
        cmp++; if (bus.Arbiter_ARID_control !== 4'b1010) begin errs++; $display("FAIL s1_ctrl got %b exp 1010", bus.Arbiter_ARID_control); end
        cmp++; if (bus.Aibiter_Read_State_control !== 2'b00) begin errs++; $display("FAIL s1_idle got %b exp 00", bus.Aibiter_Read_State_control); end
        for (int i = 0; i < 3; i++) begin
            tick();
            if (i == 1) begin
                bus.ARVALID_M0 = 1; bus.ARADDR_M0 = 32'h0000_0000; bus.ARREADY_S0 = 1;
                bus.RVALID_S1 = 1; bus.RLAST_S1 = 1; bus.RREADY_M1 = 1;
            end
            #1;
            cmp++; if (bus.Aibiter_Read_State_control !== 2'b01 || bus.Arbiter_ARID_control !== 4'b1010) begin errs++; $display("FAIL s1_addr%0d got st %b ctrl %b exp st 01 ctrl 1010", i, bus.Aibiter_Read_State_control, bus.Arbiter_ARID_control); end
        end
        bus.ARVALID_M0 = 0; bus.ARREADY_S0 = 0;
        bus.RVALID_S1 = 0; bus.RLAST_S1 = 0; bus.RREADY_M1 = 0;
        bus.ARREADY_S1 = 1;
        tick();
        cmp++; if (bus.Aibiter_Read_State_control !== 2'b10) begin errs++; $display("FAIL s1_data got %b exp 10", bus.Aibiter_Read_State_control); end
        bus.ARVALID_M1 = 0; bus.ARREADY_S1 = 0;
        bus.RVALID_S1 = 1; bus.RLAST_S1 = 1; bus.RREADY_M1 = 1;
        tick();
        cmp++; if (bus.Aibiter_Read_State_control !== 2'b00) begin errs++; $display("FAIL s1_done got %b exp 00", bus.Aibiter_Read_State_control); end
        clear_inputs();
    endtask

    task automatic test_sd;
        bus.ARVALID_M0 = 1; bus.ARADDR_M0 = 32'h0003_0000; bus.ARREADY_SD = 1;
        #1;
        cmp++; if (bus.Arbiter_ARID_control !== 4'b0100) begin errs++; $display("FAIL sd_ctrl got %b exp 0100", bus.Arbiter_ARID_control); end
        tick();
        bus.ARVALID_M0 = 0; bus.ARREADY_SD = 0;
        bus.RVALID_S0 = 1; bus.RLAST_S0 = 1; bus.RREADY_M0 = 1;
        tick();
        cmp++; if (bus.Aibiter_Read_State_control !== 2'b10) begin errs++; $display("FAIL sd_wrong_target got %b exp 10", bus.Aibiter_Read_State_control); end
        bus.RVALID_S0 = 0; bus.RLAST_S0 = 0;
        bus.RVALID_SD = 1; bus.RLAST_SD = 1;
        tick();
        cmp++; if (bus.Aibiter_Read_State_control !== 2'b00) begin errs++; $display("FAIL sd_done got %b exp 00", bus.Aibiter_Read_State_control); end
        clear_inputs();
    endtask

    task automatic test_rready_stall;
        bus.ARVALID_M0 = 1; bus.ARADDR_M0 = 32'h0001_0000; bus.ARREADY_S1 = 1;
        #1;
        cmp++; if (bus.Arbiter_ARID_control !== 4'b0010) begin errs++; $display("FAIL stall_ctrl got %b exp 0010", bus.Arbiter_ARID_control); end
        tick();
        bus.ARVALID_M0 = 0; bus.ARREADY_S1 = 0;
        bus.RVALID_S1 = 1; bus.RLAST_S1 = 1; bus.RREADY_M0 = 0; bus.RREADY_M1 = 1;
        for (int i = 0; i < 2; i++) begin
            tick();
            cmp++; if (bus.Aibiter_Read_State_control !== 2'b10) begin errs++; $display("FAIL stall_hold%0d got %b exp 10", i, bus.Aibiter_Read_State_control); end
        end
        bus.RREADY_M0 = 1;
        tick();
        cmp++; if (bus.Aibiter_Read_State_control !== 2'b00) begin errs++; $display("FAIL stall_exit got %b exp 00", bus.Aibiter_Read_State_control); end
        clear_inputs();
    endtask

    task automatic test_reset_mid_data;
        bus.ARVALID_M0 = 1; bus.ARADDR_M0 = 32'h0000_0010; bus.ARREADY_S0 = 1;
        tick();
        bus.ARVALID_M0 = 0; bus.ARREADY_S0 = 0;
        #1;
        cmp++; if (bus.Aibiter_Read_State_control !== 2'b10) begin errs++; $display("FAIL rst_pre_data got %b exp 10", bus.Aibiter_Read_State_control); end
        #1;
        ARESETn = 0;
        #1;
        cmp++; if (bus.Aibiter_Read_State_control !== 2'b00) begin errs++; $display("FAIL rst_async_state got %b exp 00", bus.Aibiter_Read_State_control); end
        cmp++; if (bus.Arbiter_ARID_control !== 4'b0000) begin errs++; $display("FAIL rst_async_ctrl got %b exp 0000", bus.Arbiter_ARID_control); end
        cmp++; if (bus.rd_busy !== 1'b0) begin errs++; $display("FAIL rst_async_busy got %b exp 0", bus.rd_busy); end
        tick();
        ARESETn = 1;
        bus.ARVALID_M0 = 1; bus.ARADDR_M0 = 32'h0000_0020;
        bus.ARVALID_M1 = 1; bus.ARADDR_M1 = 32'h0001_0020;
        bus.ARREADY_S0 = 1; bus.ARREADY_S1 = 1;
        #1;
        cmp++; if (bus.Arbiter_ARID_control !== 4'b0001) begin errs++; $display("FAIL rst_first_grant got %b exp 0001", bus.Arbiter_ARID_control); end
        tick();
        cmp++; if (bus.Aibiter_Read_State_control !== 2'b10 || bus.Arbiter_ARID_control !== 4'b0001) begin errs++; $display("FAIL rst_first_data got st %b ctrl %b exp st 10 ctrl 0001", bus.Aibiter_Read_State_control, bus.Arbiter_ARID_control); end
        clear_inputs();
    endtask

    initial begin
        cmp  = 0;
        errs = 0;
        test_reset();
        test_back_to_back();
        test_s0_burst();
        test_s1_wait();
        test_sd();
        test_rready_stall();
        test_reset_mid_data();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
        $finish;
    end
endmodule
